aes_run_sequencer: RTL and testbench

Run controller for the AES-256 encryption core in the side-channel evaluation top level. It launches a programmed number of back-to-back encryptions and inserts an LFSR-driven random idle gap before each launch as a timing-jitter countermeasure. It raises the oscilloscope `trigger` around each core operation and checks each ciphertext against an expected value, driving `CompareFlag_p` and error counters.

---
 rtl/aes_seq_pkg.sv | 17 +
 rtl/aes_seq_lfsr.sv | 28 ++
 rtl/aes_run_sequencer.sv | 130 +++++++++++++
 tb/tb_aes_run_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_seq_pkg.sv
// Shared types and constants for the AES run sequencer.
// Holds the FSM state encoding, the LFSR tap mask and the default LFSR seed.
package aes_seq_pkg;

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StJitter = 3'd1,
      StLaunch = 3'd2,
      StWait   = 3'd3,
      StCheck  = 3'd4,
      StFinish = 3'd5
   } seq_state_e;

   localparam logic [15:0] LfsrTaps        = 16'hB400;
   localparam logic [15:0] LfsrSeedDefault = 16'hACE1;

endpackage

// File: rtl/aes_seq_lfsr.sv
// Free-running 16-bit Galois LFSR.
// It is reloaded with SEED on reset and exposes only the low OUT_W bits.
module aes_seq_lfsr
   import aes_seq_pkg::*;
#(
   parameter logic [15:0] SEED  = LfsrSeedDefault,
   parameter int unsigned OUT_W = 4
) (
   input  logic             TOP_Clk,
   input  logic             TOP_ResetAll,
   output logic [OUT_W-1:0] lfsr_low
);

   logic [15:0] lfsr_q, lfsr_d;

   always_comb begin
      lfsr_d = lfsr_q >> 1;
      if (lfsr_q[0]) lfsr_d = lfsr_d ^ LfsrTaps;
   end

   always_ff @(posedge TOP_Clk or posedge TOP_ResetAll) begin
      if (TOP_ResetAll) lfsr_q <= SEED;
      else              lfsr_q <= lfsr_d;
   end

   assign lfsr_low = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/aes_run_sequencer.sv
// Batch run controller for the AES core: it inserts a random pre-launch gap and drives the scope
// trigger. It also compares each ciphertext against a reference and keeps pass/fail counters.
module aes_run_sequencer
   import aes_seq_pkg::*;
#(
   parameter int unsigned DATA_W    = 128,
   parameter int unsigned RUNS_W    = 16,
   parameter int unsigned DELAY_W   = 4,
   parameter int unsigned TIMEOUT   = 64,
   parameter logic [15:0] LFSR_SEED = LfsrSeedDefault
) (
   input  logic              TOP_Clk,
   input  logic              TOP_ResetAll,
   input  logic              start,
   input  logic [RUNS_W-1:0] num_runs,
   input  logic              jitter_en,
   input  logic [DATA_W-1:0] expected_ct,
   output logic              core_start,
   input  logic              core_done,
   input  logic [DATA_W-1:0] core_ct,
   output logic              trigger,
   output logic              CompareFlag_p,
   output logic [RUNS_W-1:0] run_cnt,
   output logic [RUNS_W-1:0] fail_cnt,
   output logic              timeout_err,
   output logic              busy,
   output logic              batch_done
);

   localparam int unsigned     TmoW    = $clog2(TIMEOUT + 1);
   localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);

   seq_state_e state_q, state_d;

   logic [RUNS_W-1:0]  runs_q, run_cnt_q, fail_cnt_q, run_cnt_inc;
   logic               jit_en_q, flag_q, tmo_q;
   logic [DELAY_W-1:0] delay_q, lfsr_low;
   logic [TmoW-1:0]    wait_cnt_q;
   logic [DATA_W-1:0]  ct_q;

   aes_seq_lfsr #(
      .SEED  (LFSR_SEED),
      .OUT_W (DELAY_W)
   ) u_lfsr (
      .TOP_Clk      (TOP_Clk),
      .TOP_ResetAll (TOP_ResetAll),
      .lfsr_low     (lfsr_low)
   );

   assign run_cnt_inc = run_cnt_q + 1'b1;

   always_ff @(posedge TOP_Clk or posedge TOP_ResetAll) begin
      if (TOP_ResetAll) state_q <= StIdle;
      else              state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (start) state_d = (num_runs == '0) ? StFinish : StJitter;
         StJitter: if (delay_q == '0) state_d = StLaunch;
         StLaunch: state_d = StWait;
         // A done pulse in the expiry cycle still counts as a completed run.
         StWait: begin
            if (core_done)                   state_d = StCheck;
            else if (wait_cnt_q == TmoLast) state_d = StFinish;
         end
         StCheck:  state_d = (run_cnt_inc == runs_q) ? StFinish : StJitter;
         StFinish: state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   always_comb begin
      core_start = (state_q == StLaunch);
      trigger    = (state_q == StLaunch) || (state_q == StWait);
      busy       = (state_q != StIdle);
      batch_done = (state_q == StFinish);
   end

   always_ff @(posedge TOP_Clk or posedge TOP_ResetAll) begin
      if (TOP_ResetAll) begin
         runs_q     <= '0;
         jit_en_q   <= 1'b0;
         run_cnt_q  <= '0;
         fail_cnt_q <= '0;
         flag_q     <= 1'b0;
         tmo_q      <= 1'b0;
         delay_q    <= '0;
         wait_cnt_q <= '0;
         ct_q       <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  runs_q     <= num_runs;
                  jit_en_q   <= jitter_en;
                  run_cnt_q  <= '0;
                  fail_cnt_q <= '0;
                  flag_q     <= 1'b0;
                  tmo_q      <= 1'b0;
                  delay_q    <= jitter_en ? lfsr_low : '0;
               end
            end
            StJitter: if (delay_q != '0) delay_q <= delay_q - 1'b1;
            StLaunch: wait_cnt_q <= '0;
            StWait: begin
               if (core_done)                   ct_q       <= core_ct;
               else if (wait_cnt_q == TmoLast) tmo_q      <= 1'b1;
               else                             wait_cnt_q <= wait_cnt_q + 1'b1;
            end
            StCheck: begin
               flag_q    <= (ct_q == expected_ct);
               run_cnt_q <= run_cnt_inc;
               if ((ct_q != expected_ct) && (fail_cnt_q != {RUNS_W{1'b1}})) begin
                  fail_cnt_q <= fail_cnt_q + 1'b1;
               end
               delay_q <= jit_en_q ? lfsr_low : '0;
            end
            default: ;
         endcase
      end
   end

   assign CompareFlag_p = flag_q;
   assign run_cnt       = run_cnt_q;
   assign fail_cnt      = fail_cnt_q;
   assign timeout_err   = tmo_q;

endmodule

// File: tb/tb_aes_run_sequencer.sv
// Randomized scoreboard bench for aes_run_sequencer.
// A behavioural core model pushes expectations; independent monitors pop and compare them.
module tb_aes_run_sequencer;

   localparam int unsigned DATA_W  = 128;
   localparam int unsigned RUNS_W  = 16;
   localparam int unsigned DELAY_W = 4;
   localparam int unsigned TIMEOUT = 64;
   localparam logic [15:0] SEED    = 16'hACE1;

   logic              clk = 1'b0, rst = 1'b0;
   logic              start = 1'b0, jitter_en = 1'b0;
   logic              core_done_m = 1'b0, core_done_x = 1'b0, core_done;
   logic [RUNS_W-1:0] num_runs = '0;
   logic [DATA_W-1:0] expected_ct = '0, core_ct = '0;
   logic              core_start, trigger, CompareFlag_p, timeout_err, busy, batch_done;
   logic [RUNS_W-1:0] run_cnt, fail_cnt;

   assign core_done = core_done_m | core_done_x;

   aes_run_sequencer #(
      .DATA_W    (DATA_W),
      .RUNS_W    (RUNS_W),
      .DELAY_W   (DELAY_W),
      .TIMEOUT   (TIMEOUT),
      .LFSR_SEED (SEED)
   ) dut (
      .TOP_Clk       (clk),
      .TOP_ResetAll  (rst),
      .start         (start),
      .num_runs      (num_runs),
      .jitter_en     (jitter_en),
      .expected_ct   (expected_ct),
      .core_start    (core_start),
      .core_done     (core_done),
      .core_ct       (core_ct),
      .trigger       (trigger),
      .CompareFlag_p (CompareFlag_p),
      .run_cnt       (run_cnt),
      .fail_cnt      (fail_cnt),
      .timeout_err   (timeout_err),
      .busy          (busy),
      .batch_done    (batch_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      int runs;
      int fails;
      bit flag;
      bit tmo;
   } summ_t;

   summ_t bat_q[$], res_q[$];
   int    jit_q[$], trig_q[$];
   int    errors = 0, checks = 0;
   int    edges = 0;

   // Batch context shared between the start driver and the core model.
   int b_runs = 0, b_done = 0, b_fail = 0;
   bit b_flag = 0, b_jit = 0;
   int mode = 0;         // 0 respond, 1 never respond (timeout), 2 never respond (reset test)
   int lat_fixed = 10;   // 0 selects a random latency
   int corrupt_run = 0;
   bit rand_corrupt = 0;

   // Clock edges since reset release: the DUT LFSR has stepped exactly this many times.
   always @(posedge clk or posedge rst) begin
      if (rst) edges <= 0;
      else     edges <= edges + 1;
   end

   function automatic summ_t mk(input int runs, input int fails, input bit flag, input bit tmo);
      summ_t s;
      s.runs  = runs;
      s.fails = fails;
      s.flag  = flag;
      s.tmo   = tmo;
      return s;
   endfunction

   // Delay drawn when the LFSR holds the value reached after n steps from the seed.
   function automatic int jit_delay(input int n, input bit en);
      logic [15:0] v;
      v = SEED;
      for (int i = 0; i < n; i++) v = v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
      return en ? int'(v[DELAY_W-1:0]) : 0;
   endfunction

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic issue_start(input int n, input bit jit);
      @(negedge clk);
      num_runs    = RUNS_W'(n);
      jitter_en   = jit;
      expected_ct = {$urandom, $urandom, $urandom, $urandom};
      b_runs = n; b_jit = jit; b_done = 0; b_fail = 0; b_flag = 0;
      if (n == 0) bat_q.push_back(mk(0, 0, 1'b0, 1'b0));
      else        jit_q.push_back(edges + 2 + jit_delay(edges, jit));
      start = 1'b1;
      @(negedge clk);
      start     = 1'b0;
      num_runs  = RUNS_W'($urandom);
      jitter_en = $urandom_range(0, 1);
   endtask

   task automatic wait_idle(input string name);
      for (int k = 0; k < 5000 && busy; k++) @(negedge clk);
      check(name, busy, 0);
   endtask

   // Core model: answers each launch after a latency, optionally with a corrupted ciphertext.
   int               lat;
   bit               bad;
   logic [DATA_W-1:0] flip;
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && core_start) begin
            if (mode == 1) begin
               trig_q.push_back(TIMEOUT + 1);
               bat_q.push_back(mk(b_done, b_fail, b_flag, 1'b1));
            end else if (mode == 0) begin
               lat = (lat_fixed != 0) ? lat_fixed : $urandom_range(1, 12);
               b_done++;
               bad = (b_done == corrupt_run) || (rand_corrupt && $urandom_range(0, 2) == 0);
               trig_q.push_back(lat + 1);
               repeat (lat) @(negedge clk);
               flip = '0;
               flip[$urandom_range(0, DATA_W - 1)] = 1'b1;
               core_ct     = bad ? (expected_ct ^ flip) : expected_ct;
               core_done_m = 1'b1;
               if (bad && b_fail < 65535) b_fail++;
               b_flag = !bad;
               res_q.push_back(mk(b_done, b_fail, b_flag, 1'b0));
               // Done seen at edge X+1, CHECK left at X+2, launch d+1 edges later.
               if (b_done < b_runs) jit_q.push_back(edges + 3 + jit_delay(edges + 1, b_jit));
               else                 bat_q.push_back(mk(b_done, b_fail, b_flag, 1'b0));
               @(negedge clk);
               core_done_m = 1'b0;
               core_ct     = {$urandom, $urandom, $urandom, $urandom};
            end
         end
      end
   end

   // Launch monitor: each core_start must land on the predicted edge.
   int mj_e;
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && core_start) begin
            if (jit_q.size() == 0) check("unexpected launch", 1, 0);
            else begin
               mj_e = jit_q.pop_front();
               check("launch edge", edges, mj_e);
            end
         end
      end
   end

   // Trigger monitor: length of each high window.
   int trig_len = 0;
   int mt_e;
   initial begin
      forever begin
         @(negedge clk);
         if (rst) trig_len = 0;
         else if (trigger) trig_len++;
         else if (trig_len != 0) begin
            if (trig_q.size() == 0) check("unexpected trigger", 1, 0);
            else begin
               mt_e = trig_q.pop_front();
               check("trigger length", trig_len, mt_e);
            end
            trig_len = 0;
         end
      end
   end

   // Result monitor: every increment of run_cnt is one completed comparison.
   logic [RUNS_W-1:0] prev_run = '0;
   summ_t             mr;
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && run_cnt != prev_run && run_cnt != '0) begin
            if (res_q.size() == 0) check("unexpected result", 1, 0);
            else begin
               mr = res_q.pop_front();
               check("run_cnt", run_cnt, mr.runs);
               check("fail_cnt", fail_cnt, mr.fails);
               check("CompareFlag_p", CompareFlag_p, mr.flag);
            end
         end
         prev_run = run_cnt;
      end
   end

   // Batch monitor: summary at every batch_done pulse.
   summ_t mb;
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && batch_done) begin
            if (bat_q.size() == 0) check("unexpected batch_done", 1, 0);
            else begin
               mb = bat_q.pop_front();
               check("batch run_cnt", run_cnt, mb.runs);
               check("batch fail_cnt", fail_cnt, mb.fails);
               check("batch flag", CompareFlag_p, mb.flag);
               check("batch timeout_err", timeout_err, mb.tmo);
               check("batch busy", busy, 1);
               check("batch pending launches", jit_q.size(), 0);
               check("batch pending results", res_q.size(), 0);
            end
         end
      end
   end

   initial begin
      #1 rst = 1'b1;
      #20;
      check("reset outputs", {core_start, trigger, busy, batch_done, timeout_err, CompareFlag_p}, 0);
      check("reset run_cnt", run_cnt, 0);
      check("reset fail_cnt", fail_cnt, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // Three clean runs, no jitter, 10-cycle core.
      mode = 0; lat_fixed = 10; corrupt_run = 0; rand_corrupt = 0;
      issue_start(3, 1'b0);
      wait_idle("idle after clean batch");

      // Run 2 of 4 corrupted.
      corrupt_run = 2;
      issue_start(4, 1'b0);
      wait_idle("idle after corrupt batch");
      corrupt_run = 0;

      // Twenty jittered runs with random core latency.
      lat_fixed = 0;
      repeat (7) @(negedge clk);
      issue_start(20, 1'b1);
      wait_idle("idle after jitter batch");

      // Core never answers: timeout aborts the batch.
      mode = 1;
      issue_start(2, 1'b0);
      wait_idle("idle after timeout");
      check("timeout_err sticky", timeout_err, 1);
      mode = 0;

      // Zero-length batch: immediate batch_done, clears timeout_err.
      issue_start(0, 1'b0);
      check("zero batch_done", batch_done, 1);
      check("zero core_start", core_start, 0);
      check("zero timeout_err cleared", timeout_err, 0);
      wait_idle("idle after zero batch");

      // Reset during WAIT.
      mode = 2;
      issue_start(2, 1'b0);
      for (int k = 0; k < 200 && !(trigger && !core_start); k++) @(negedge clk);
      check("reached WAIT", trigger && !core_start, 1);
      repeat (3) @(negedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("mid-run reset outputs",
            {core_start, trigger, busy, batch_done, timeout_err, CompareFlag_p}, 0);
      check("mid-run reset run_cnt", run_cnt, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk) core_done_x = 1'b1;
      @(negedge clk) core_done_x = 1'b0;
      @(negedge clk);
      check("spurious done busy", busy, 0);
      check("spurious done run_cnt", run_cnt, 0);
      mode = 0; lat_fixed = 5;
      issue_start(2, 1'b1);
      wait_idle("idle after post-reset batch");

      // Random batches.
      lat_fixed = 0; rand_corrupt = 1;
      for (int b = 0; b < 8; b++) begin
         repeat ($urandom_range(0, 9)) @(negedge clk);
         issue_start($urandom_range(1, 6), 1'($urandom_range(0, 1)));
         wait_idle("idle after random batch");
      end

      repeat (4) @(negedge clk);
      check("leftover batches", bat_q.size(), 0);
      check("leftover results", res_q.size(), 0);
      check("leftover launches", jit_q.size(), 0);
      check("leftover triggers", trig_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
